// File: rtl/relu_pkg.sv
// Shared data-width constant and signed data type for the ReLU gradient slice.
package relu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic signed [DATA_W-1:0] data_t;

endpackage

// File: rtl/relu_mask_fifo.sv
// 1-bit wide mask FIFO: one bit per forward activation, popped in order by the gradient stream.
module relu_mask_fifo #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     push_bit_i,
    input  logic                     pop_i,
    output logic                     pop_bit_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_bit_o = mem_q[rd_ptr_q];

    // Guard against overflow/underflow even if the caller misbehaves.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count and pointers define which bits are live.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_bit_i;
        end
    end

endmodule

// File: rtl/relu_grad.sv
// ReLU backward gate: stores forward sign masks and gates the upstream gradient with them.
// Optional leaky slope for negative activations enabled by defining RELU_GRAD_LEAKY_EN.
module relu_grad
    import relu_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     fwd_valid,
    output logic                     fwd_ready,
    input  logic [DATA_W-1:0]        fwd_result,
    input  logic                     grad_in_valid,
    output logic                     grad_in_ready,
    input  logic [DATA_W-1:0]        grad_in,
    output logic                     grad_out_valid,
    input  logic                     grad_out_ready,
    output logic [DATA_W-1:0]        grad_out,
    output logic [$clog2(DEPTH):0]   mask_count
);

    logic        en_q;
    logic        fifo_full, fifo_empty, pop_bit;
    logic        push, pop;
    logic        out_valid_q, out_valid_d;
    data_t       out_data_q, out_data_d;
    data_t       gated;

    // Handshakes stay low during reset and come up on the first edge after release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    assign fwd_ready     = en_q & ~fifo_full;
    assign grad_in_ready = en_q & ~fifo_empty & (~out_valid_q | grad_out_ready);
    assign push          = fwd_valid & fwd_ready;
    assign pop           = grad_in_valid & grad_in_ready;

    // Only the sign bit of the forward result matters.
    logic unused_fwd_bits;
    assign unused_fwd_bits = ^fwd_result[DATA_W-2:0];

    relu_mask_fifo #(
        .DEPTH (DEPTH)
    ) u_mask_fifo (
        .clk_i      (aclk),
        .rst_ni     (aresetn),
        .push_i     (push),
        .push_bit_i (~fwd_result[DATA_W-1]),
        .pop_i      (pop),
        .pop_bit_o  (pop_bit),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (mask_count)
    );

`ifdef RELU_GRAD_LEAKY_EN
    always_comb begin
        gated = data_t'(grad_in) >>> LEAK_SHIFT;
        if (pop_bit) begin
            gated = data_t'(grad_in);
        end
    end
`else
    logic [DATA_W-1:0] unused_leak_shift;
    assign unused_leak_shift = DATA_W'(LEAK_SHIFT);

    always_comb begin
        gated = '0;
        if (pop_bit) begin
            gated = data_t'(grad_in);
        end
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = gated;
        end else if (grad_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign grad_out_valid = out_valid_q;
    assign grad_out       = out_data_q;

endmodule

// File: tb/tb_relu_grad.sv
// Directed self-checking bench for relu_grad (default DEPTH=64, LEAK_SHIFT=3).
module tb_relu_grad;

    localparam int unsigned DEPTH      = 64;
    localparam int unsigned LEAK_SHIFT = 3;
    localparam int unsigned CW         = $clog2(DEPTH) + 1;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          fwd_valid = 1'b0;
    logic          fwd_ready;
    logic [31:0]   fwd_result = '0;
    logic          grad_in_valid = 1'b0;
    logic          grad_in_ready;
    logic [31:0]   grad_in = '0;
    logic          grad_out_valid;
    logic          grad_out_ready = 1'b0;
    logic [31:0]   grad_out;
    logic [CW-1:0] mask_count;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    relu_grad #(
        .DEPTH      (DEPTH),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .fwd_result     (fwd_result),
        .grad_in_valid  (grad_in_valid),
        .grad_in_ready  (grad_in_ready),
        .grad_in        (grad_in),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .grad_out       (grad_out),
        .mask_count     (mask_count)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] ref_out(input logic m, input logic [31:0] g);
        if (m) return g;
`ifdef RELU_GRAD_LEAKY_EN
        return 32'($signed(g) >>> LEAK_SHIFT);
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset();
        repeat (3) begin
            tick();
            checks++;
            if ({fwd_ready, grad_in_ready, grad_out_valid} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hs: got %b want 000", {fwd_ready, grad_in_ready, grad_out_valid});
            end
        end
        checks++;
        if (mask_count !== '0 || grad_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: count=%0d out=%h want 0/0", mask_count, grad_out);
        end
        aresetn = 1'b1;
        #2;
        checks++;
        if (fwd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b want 0", fwd_ready);
        end
        tick();
        checks++;
        if (fwd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b want 1", fwd_ready);
        end
    endtask

    task automatic test_gating();
        logic [31:0] res [4] = '{32'd5, -32'sd3, 32'd0, 32'h8000_0000};
`ifdef RELU_GRAD_LEAKY_EN
        logic [31:0] exp [4] = '{32'd10, 32'd1, 32'd10, 32'd1};
`else
        logic [31:0] exp [4] = '{32'd10, 32'd0, 32'd10, 32'd0};
`endif
        fwd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fwd_result = res[i];
            tick();
        end
        fwd_valid = 1'b0;
        fwd_result = 32'hdead_beef;
        checks++;
        if (mask_count !== CW'(4)) begin
            errors++;
            $display("FAIL gate_count: got %0d want 4", mask_count);
        end
        grad_out_ready = 1'b1;
        grad_in_valid = 1'b1;
        grad_in = 32'd10;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (grad_out_valid !== 1'b1 || grad_out !== exp[i]) begin
                errors++;
                $display("FAIL gate_out%0d: got v=%b %0d want v=1 %0d", i, grad_out_valid, grad_out, exp[i]);
            end
        end
        grad_in_valid = 1'b0;
        tick();
        checks++;
        if (grad_out_valid !== 1'b0 || mask_count !== '0) begin
            errors++;
            $display("FAIL gate_drain: got v=%b count=%0d want 0/0", grad_out_valid, mask_count);
        end
    endtask

    task automatic test_full();
        fwd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_result = 32'(i);
            tick();
        end
        checks++;
        if (fwd_ready !== 1'b0 || mask_count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL full_flag: got rdy=%b count=%0d want 0/%0d", fwd_ready, mask_count, DEPTH);
        end
        fwd_result = -32'sd1;
        tick();
        checks++;
        if (mask_count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL full_no_push: got %0d want %0d", mask_count, DEPTH);
        end
        fwd_valid = 1'b0;
        grad_in_valid = 1'b1;
        grad_in = 32'd100;
        tick();
        checks++;
        if (fwd_ready !== 1'b1 || mask_count !== CW'(DEPTH - 1) || grad_out !== 32'd100) begin
            errors++;
            $display("FAIL full_pop: got rdy=%b count=%0d out=%0d want 1/%0d/100", fwd_ready, mask_count,
                     grad_out, DEPTH - 1);
        end
        for (int i = 1; i < DEPTH; i++) begin
            grad_in = 32'(100 + i);
            tick();
            checks++;
            if (grad_out !== 32'(100 + i)) begin
                errors++;
                $display("FAIL full_drain%0d: got %0d want %0d", i, grad_out, 100 + i);
            end
        end
        grad_in_valid = 1'b0;
        tick();
        checks++;
        if (mask_count !== '0 || grad_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got count=%0d v=%b want 0/0", mask_count, grad_out_valid);
        end
    endtask

    task automatic test_empty();
        grad_in_valid = 1'b1;
        grad_in = 32'd77;
        #1;
        checks++;
        if (grad_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_ready: got %b want 0", grad_in_ready);
        end
        repeat (3) begin
            tick();
            checks++;
            if (grad_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_valid: got %b want 0", grad_out_valid);
            end
        end
        grad_in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
`ifdef RELU_GRAD_LEAKY_EN
        logic [31:0] exp2 = 32'd5;
`else
        logic [31:0] exp2 = 32'd0;
`endif
        fwd_valid = 1'b1;
        fwd_result = 32'd7;
        tick();
        fwd_result = -32'sd1;
        tick();
        fwd_valid = 1'b0;
        grad_out_ready = 1'b0;
        grad_in_valid = 1'b1;
        grad_in = 32'd33;
        tick();
        checks++;
        if (grad_out_valid !== 1'b1 || grad_out !== 32'd33 || mask_count !== CW'(1)) begin
            errors++;
            $display("FAIL bp_load: got v=%b out=%0d count=%0d want 1/33/1", grad_out_valid, grad_out,
                     mask_count);
        end
        grad_in = 32'd44;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (grad_out_valid !== 1'b1 || grad_out !== 32'd33 || grad_in_ready !== 1'b0 ||
                mask_count !== CW'(1)) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b out=%0d rdy=%b count=%0d want 1/33/0/1", i,
                         grad_out_valid, grad_out, grad_in_ready, mask_count);
            end
        end
        grad_out_ready = 1'b1;
        #1;
        checks++;
        if (grad_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got %b want 1", grad_in_ready);
        end
        tick();
        checks++;
        if (grad_out_valid !== 1'b1 || grad_out !== exp2) begin
            errors++;
            $display("FAIL bp_second: got v=%b out=%0d want 1/%0d", grad_out_valid, grad_out, exp2);
        end
        grad_in_valid = 1'b0;
        tick();
        checks++;
        if (grad_out_valid !== 1'b0 || mask_count !== '0) begin
            errors++;
            $display("FAIL bp_done: got v=%b count=%0d want 0/0", grad_out_valid, mask_count);
        end
    endtask

    task automatic test_back_to_back();
        logic        mq[$];
        logic [31:0] r, g, e;
        grad_out_ready = 1'b1;
        fwd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            fwd_result = r;
            mq.push_back(~r[31]);
            tick();
        end
        grad_in_valid = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            r = $urandom;
            g = $urandom;
            fwd_result = r;
            grad_in = g;
            e = ref_out(mq.pop_front(), g);
            mq.push_back(~r[31]);
            tick();
            checks++;
            if (grad_out_valid !== 1'b1 || grad_out !== e || mask_count !== CW'(8)) begin
                errors++;
                $display("FAIL b2b%0d: got v=%b out=%h count=%0d want 1/%h/8", i, grad_out_valid,
                         grad_out, mask_count, e);
            end
        end
        fwd_valid = 1'b0;
        grad_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        fwd_valid = 1'b1;
        fwd_result = 32'd1;
        repeat (3) tick();
        fwd_valid = 1'b0;
        grad_out_ready = 1'b0;
        grad_in_valid = 1'b1;
        grad_in = 32'd9;
        tick();
        grad_in_valid = 1'b0;
        checks++;
        if (mask_count !== CW'(10) || grad_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_setup: got count=%0d v=%b want 10/1", mask_count, grad_out_valid);
        end
        #3;
        aresetn = 1'b0;
        #1;
        checks++;
        if (mask_count !== '0 || grad_out_valid !== 1'b0 || grad_out !== 32'd0 ||
            fwd_ready !== 1'b0 || grad_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_clear: got count=%0d v=%b out=%0d frdy=%b grdy=%b want all 0", mask_count,
                     grad_out_valid, grad_out, fwd_ready, grad_in_ready);
        end
        tick();
        aresetn = 1'b1;
        grad_out_ready = 1'b1;
        tick();
        checks++;
        if (fwd_ready !== 1'b1 || mask_count !== '0 || grad_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_recover: got rdy=%b count=%0d v=%b want 1/0/0", fwd_ready, mask_count,
                     grad_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_gating();
        test_full();
        test_empty();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/relu_grad.md
RELU_GRAD -- requirements
Module: relu_grad

Interface
REQ-001 SHALL have parameter DEPTH, default 64: mask buffer entries; power of 2, 2..1024.
REQ-002 SHALL have parameter LEAK_SHIFT, default 3: right-shift amount for the leaky slope; used only under RELU_GRAD_LEAKY_EN.
REQ-003 SHALL have port aclk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port aresetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports fwd_valid input 1 / fwd_ready output 1 / fwd_result input 32: forward pre-activation stream, signed 32-bit.
REQ-006 SHALL have ports grad_in_valid input 1 / grad_in_ready output 1 / grad_in input 32: upstream gradient stream, signed 32-bit.
REQ-007 SHALL have ports grad_out_valid output 1 / grad_out_ready input 1 / grad_out output 32: gated gradient stream, signed 32-bit.
REQ-008 SHALL have port mask_count  output  $clog2(DEPTH)+1  number of stored mask bits.

Function
REQ-009 SHALL transfer on any stream only when valid and ready are both high on a clock edge.
REQ-010 SHALL, on each fwd transfer, push mask bit = ~fwd_result[31] (result >= 0 gives 1; zero counts as pass-through).
REQ-011 SHALL drive fwd_ready = (mask_count < DEPTH), i.e. low when full.
REQ-012 SHALL pop mask bits in FIFO order, one per grad_in transfer.
REQ-013 SHALL drive grad_in_ready = (mask_count != 0) AND (output register empty OR grad_out_ready).
REQ-014 SHALL, on a grad_in transfer, load the output register on the same edge with grad_in if the popped bit is 1, else 0; grad_out_valid asserts the following cycle (latency 1).
REQ-015 SHALL hold grad_out and grad_out_valid stable while grad_out_valid=1 and grad_out_ready=0.
REQ-016 SHALL clear grad_out_valid after a grad_out transfer unless a new grad_in transfer occurs on the same edge.
REQ-017 SHALL, on simultaneous push and pop, leave mask_count unchanged; when full, a pop and a push on the same edge are both allowed only if fwd_ready was high, i.e. never push while full.
REQ-018 SHALL allow a push into an empty buffer and pop it no earlier than the following cycle (no fall-through).
REQ-019 SHALL wrap read and write pointers modulo DEPTH.
REQ-020 SHALL ignore fwd_result and grad_in when their valid is low.

Reset
REQ-021 SHALL, while aresetn=0, force mask_count=0, pointers=0, grad_out_valid=0, grad_out=0, fwd_ready=0, grad_in_ready=0.
REQ-022 SHALL discard all stored mask bits and any held output on reset asserted mid-operation.
REQ-023 SHALL drive fwd_ready=1 on the first clock edge after aresetn deasserts.

Configuration
REQ-024 SHALL, with RELU_GRAD_LEAKY_EN defined, output grad_in >>> LEAK_SHIFT (arithmetic) for popped mask bit 0.
REQ-025 SHALL, without RELU_GRAD_LEAKY_EN, output exactly 0 for popped mask bit 0, and the LEAK_SHIFT parameter is unused.

Structure
REQ-026 SHALL place the DATA_W=32 constant and the signed data typedef in shared package relu_pkg.
REQ-027 SHALL implement mask storage as sub-module relu_mask_fifo (1-bit wide, DEPTH deep, push/pop/count); relu_grad holds the handshake and the output register.

Verification
REQ-028 SHALL cover this scenario: push results {5, -3, 0, 0x80000000}, then grads {10,10,10,10} with grad_out_ready=1 -> grad_out {10,0,10,0}; with LEAKY_EN and LEAK_SHIFT=3 -> {10,1,10,1}.
REQ-029 SHALL cover this scenario: push DEPTH results -> fwd_ready=0 and mask_count=DEPTH; one grad pop -> fwd_ready=1 the next cycle.
REQ-030 SHALL cover this scenario: grad_in_valid=1 with mask_count=0 -> grad_in_ready=0 and no grad_out_valid.
REQ-031 SHALL cover this scenario: grad_out_ready=0 for 5 cycles with output held -> grad_out stable, grad_in_ready=0, and no mask pop.
REQ-032 SHALL cover this scenario: continuous simultaneous push and pop across 3*DEPTH transfers -> mask_count constant, pointers wrap, and order matches a reference queue.
REQ-033 SHALL cover this scenario: aresetn pulsed low with 10 entries stored and output valid -> mask_count=0 and grad_out_valid=0 immediately (asynchronously).
